// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - select-line sequencer that steps a 4:1 mux and captures its output per channel
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_in,
    output logic       sel0,
    output logic       sel1,
    output logic       sample,
    output logic [3:0] result,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       result_q, result_d;
    logic             sample_w;

    assign sample_w = (state_q == ST_RUN) && (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    ch_d     = 2'd0;
                    cnt_d    = CNT_LOAD;
                    result_d = 4'b0000;
                end
            end
            ST_RUN: begin
                if (!sample_w) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    result_d[ch_q] = mux_in;
                    if (ch_q != 2'd3) begin
                        ch_d  = ch_q + 2'd1;
                        cnt_d = CNT_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Continuous mode overwrites result in place rather than clearing it
                ch_d = 2'd0;
                if (cont) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= '0;
            result_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign sel0   = ch_q[0];
    assign sel1   = ch_q[1];
    assign sample = sample_w;
    assign result = result_q;
    assign busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl with DWELL=4 and DWELL=1 instances
module tb_mux_scan_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic       start0 = 1'b0, cont0 = 1'b0;
    logic [3:0] din0 = 4'b0000;
    logic       sel0_0, sel1_0, sample0, busy0, done0;
    logic [3:0] result0;
    logic       mux_in0;

    logic       start1 = 1'b0, cont1 = 1'b0;
    logic [3:0] din1 = 4'b0000;
    logic       sel0_1, sel1_1, sample1, busy1, done1;
    logic [3:0] result1;
    logic       mux_in1;

    exp_t q_done0[$];
    exp_t q_samp0[$];
    exp_t q_done1[$];
    exp_t q_samp1[$];

    // din[3:0] = {D,C,B,A}; behaves as the combinational mux_4x1 downstream stage
    assign mux_in0 = din0[{sel1_0, sel0_0}];
    assign mux_in1 = din1[{sel1_1, sel0_1}];

    mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .cont(cont0), .mux_in(mux_in0),
        .sel0(sel0_0), .sel1(sel1_0), .sample(sample0), .result(result0),
        .busy(busy0), .done(done0)
    );

    mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cont(cont1), .mux_in(mux_in1),
        .sel0(sel0_1), .sel1(sel1_1), .sample(sample1), .result(result1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // A scan accepted at edge k samples channel n in the cycle ending at edge k+(n+1)*dwell
    task automatic expect_scan(input int which, input int k, input logic [3:0] res);
        exp_t e;
        int   dw;
        dw = (which == 0) ? 4 : 1;
        for (int n = 0; n < 4; n++) begin
            e.cyc = k + (n + 1) * dw - 1;
            e.val = 4'(n);
            if (which == 0) q_samp0.push_back(e);
            else            q_samp1.push_back(e);
        end
        e.cyc = k + 4 * dw;
        e.val = res;
        if (which == 0) q_done0.push_back(e);
        else            q_done1.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sample0) begin
                if (q_samp0.size() == 0) fail_evt("sample0_extra");
                else begin
                    e = q_samp0.pop_front();
                    chk("sample0_cycle", cyc, e.cyc);
                    chk("sample0_sel", int'({sel1_0, sel0_0}), int'(e.val));
                end
            end
            if (done0) begin
                chk("done0_sample_excl", int'(sample0), 0);
                if (q_done0.size() == 0) fail_evt("done0_extra");
                else begin
                    e = q_done0.pop_front();
                    chk("done0_cycle", cyc, e.cyc);
                    chk("done0_result", int'(result0), int'(e.val));
                end
            end
            if (sample1) begin
                if (q_samp1.size() == 0) fail_evt("sample1_extra");
                else begin
                    e = q_samp1.pop_front();
                    chk("sample1_cycle", cyc, e.cyc);
                    chk("sample1_sel", int'({sel1_1, sel0_1}), int'(e.val));
                end
            end
            if (done1) begin
                chk("done1_sample_excl", int'(sample1), 0);
                if (q_done1.size() == 0) fail_evt("done1_extra");
                else begin
                    e = q_done1.pop_front();
                    chk("done1_cycle", cyc, e.cyc);
                    chk("done1_result", int'(result1), int'(e.val));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int busy_low;

        // reset state
        #1;
        chk("rst_sel0", int'({sel1_0, sel0_0}), 0);
        chk("rst_result0", int'(result0), 0);
        chk("rst_busy_done_sample0", int'({busy0, done0, sample0}), 0);
        chk("rst_all1", int'({sel1_1, sel0_1, result1, busy1, done1, sample1}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // DWELL=1: A=1 B=1 C=0 D=0
        din1   = 4'b0011;
        start1 = 1'b1;
        k = cyc + 1;
        expect_scan(1, k, 4'b0011);
        @(negedge clk);
        start1 = 1'b0;
        wait_cyc(k + 6);
        chk("dw1_busy_after", int'(busy1), 0);

        // single scan, DWELL=4: A=0 B=1 C=0 D=1
        din0   = 4'b1010;
        start0 = 1'b1;
        k = cyc + 1;
        expect_scan(0, k, 4'b1010);
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(k + 16);
        chk("single_busy_in_done", int'(busy0), 1);
        wait_cyc(k + 17);
        chk("single_busy_fall", int'(busy0), 0);
        chk("single_sel_idle", int'({sel1_0, sel0_0}), 0);
        wait_cyc(k + 22);
        chk("single_result_hold", int'(result0), 4'b1010);

        // continuous: three scans, inputs swapped before scan 2, cont dropped in scan 3
        cont0  = 1'b1;
        start0 = 1'b1;
        k = cyc + 1;
        expect_scan(0, k, 4'b1010);
        expect_scan(0, k + 17, 4'b0101);
        expect_scan(0, k + 34, 4'b0101);
        @(negedge clk);
        start0 = 1'b0;
        busy_low = 0;
        while (cyc < k + 51) begin
            if (cyc == k + 16) din0 = 4'b0101;
            if (cyc == k + 40) cont0 = 1'b0;
            if (!busy0) busy_low++;
            @(negedge clk);
        end
        chk("cont_busy_never_low", busy_low, 0);
        chk("cont_busy_fall", int'(busy0), 0);

        // start held through RUN and DONE with cont=0
        din0   = 4'b1010;
        start0 = 1'b1;
        k = cyc + 1;
        expect_scan(0, k, 4'b1010);
        expect_scan(0, k + 18, 4'b1010);
        wait_cyc(k);
        chk("restart_result_cleared", int'(result0), 0);
        wait_cyc(k + 17);
        chk("restart_idle_gap", int'(busy0), 0);
        wait_cyc(k + 18);
        start0 = 1'b0;
        chk("restart_accepted", int'(busy0), 1);
        chk("restart_result_cleared2", int'(result0), 0);
        wait_cyc(k + 36);

        // reset mid-scan during channel 2, asserted between edges
        din0   = 4'b1001;
        start0 = 1'b1;
        k = cyc + 1;
        expect_scan(0, k, 4'b1001);
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(k + 9);
        chk("pre_rst_sel", int'({sel1_0, sel0_0}), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_sel", int'({sel1_0, sel0_0}), 0);
        chk("midrst_result", int'(result0), 0);
        chk("midrst_busy_done_sample", int'({busy0, done0, sample0}), 0);
        q_done0.delete();
        q_samp0.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", int'(busy0), 0);

        // fresh scan after reset: A=1 B=0 C=1 D=1
        din0   = 4'b1101;
        start0 = 1'b1;
        k = cyc + 1;
        expect_scan(0, k, 4'b1101);
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(k + 20);
        chk("post_rst_busy_fall", int'(busy0), 0);

        chk("pending_done0", q_done0.size(), 0);
        chk("pending_samp0", q_samp0.size(), 0);
        chk("pending_done1", q_done1.size(), 0);
        chk("pending_samp1", q_samp1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
